// File: rtl/hdb3_decode_ctrl_if.sv
// HDB3 decoder bus: line-symbol inputs (en strobe plus the two rails) and the
// decoded NRZ / status outputs. The master drives line symbols, the slave is
// the decoder.
interface hdb3_decode_ctrl_if;
  logic       en;
  logic       p_in;
  logic       n_in;
  logic       nrz_out;
  logic       nrz_valid;
  logic       v_flag;
  logic       err_flag;
  logic       lock;
  logic [7:0] err_cnt;

  modport master (
    output en, p_in, n_in,
    input  nrz_out, nrz_valid, v_flag, err_flag, lock, err_cnt
  );

  modport slave (
    input  en, p_in, n_in,
    output nrz_out, nrz_valid, v_flag, err_flag, lock, err_cnt
  );
endinterface

// File: rtl/hdb3_decode_ctrl.sv
// HDB3 line decoder with code-error monitoring.
// Each en strobe samples one bipolar symbol. Marks alternate polarity; a pulse
// that repeats the current polarity is a violation (V) and marks a substituted
// 0000 group. A 4-deep window delays the decoded bits so that the B pulse of a
// B00V group can be cleared when its V arrives. Illegal symbols, successive Vs
// of equal polarity and runs of four zeros are code errors; a run of 16
// error-free symbols declares lock.
module hdb3_decode_ctrl (
  input  logic              clk,
  input  logic              rst,
  hdb3_decode_ctrl_if.slave bus
);

  // Line symbol classes, encoded as {n_in, p_in}
  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_POS  = 2'b01,
    SYM_NEG  = 2'b10,
    SYM_ILL  = 2'b11
  } sym_t;

  // Polarity of the last mark (pol) or the last violation (last_v)
  typedef enum logic [1:0] {
    POL_NONE = 2'b00,
    POL_POS  = 2'b01,
    POL_NEG  = 2'b10
  } pol_t;

  // Zero-run value before the 4th consecutive zero, and its saturation value
  localparam logic [2:0] ZRUN_ERR  = 3'd3;
  localparam logic [2:0] ZRUN_MAX  = 3'd4;
  // Error-free symbols needed to declare lock (run counter saturates here)
  localparam logic [4:0] RUN_LOCK  = 5'd16;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Map the two rails onto a symbol class
  function automatic sym_t classify(input logic p, input logic n);
    sym_t s;
    case ({n, p})
      2'b01:   s = SYM_POS;
      2'b10:   s = SYM_NEG;
      2'b11:   s = SYM_ILL;
      default: s = SYM_ZERO;
    endcase
    return s;
  endfunction

  // Polarity carried by a pulse symbol (only meaningful for POS/NEG)
  function automatic pol_t sym_polarity(input sym_t s);
    pol_t p;
    case (s)
      SYM_NEG: p = POL_NEG;
      default: p = POL_POS;
    endcase
    return p;
  endfunction

  // Saturating 8-bit increment for the error counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == ERR_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  // Polarity state machine registers
  pol_t       pol_r;
  pol_t       last_v_r;
  pol_t       pol_nxt_s;
  pol_t       last_v_nxt_s;

  // Decode window and monitors
  logic [3:0] d_r;
  logic [3:0] vd_r;
  logic [2:0] zrun_r;
  logic [4:0] run_r;
  logic [7:0] err_cnt_r;
  logic       lock_r;

  // Registered output pulses
  logic       nrz_out_r;
  logic       nrz_valid_r;
  logic       v_flag_r;
  logic       err_flag_r;

  // Combinational decode results
  sym_t       sym_s;
  pol_t       sym_pol_s;
  logic       mark_s;
  logic       viol_s;
  logic       ill_s;
  logic       vv_err_s;
  logic       zero_err_s;
  logic       err_s;
  logic [3:0] d_nxt_s;
  logic [3:0] vd_nxt_s;
  logic [2:0] zrun_nxt_s;
  logic [4:0] run_nxt_s;
  logic [7:0] err_cnt_nxt_s;
  logic       lock_nxt_s;

  // Classify the symbol on the rails
  always_comb begin
    sym_s     = classify(bus.p_in, bus.n_in);
    sym_pol_s = sym_polarity(sym_s);
  end

  // Polarity FSM next state: mark vs violation, zero run and per-symbol errors
  always_comb begin
    pol_nxt_s    = pol_r;
    last_v_nxt_s = last_v_r;
    zrun_nxt_s   = zrun_r;
    mark_s       = 1'b0;
    viol_s       = 1'b0;
    ill_s        = 1'b0;
    vv_err_s     = 1'b0;
    zero_err_s   = 1'b0;
    case (sym_s)
      SYM_POS, SYM_NEG: begin
        zrun_nxt_s = 3'd0;
        if (pol_r == sym_pol_s) begin
          // Repeated polarity: violation; two Vs in a row must alternate
          viol_s       = 1'b1;
          last_v_nxt_s = sym_pol_s;
          if (last_v_r == sym_pol_s) begin
            vv_err_s = 1'b1;
          end else begin
            vv_err_s = 1'b0;
          end
        end else begin
          mark_s    = 1'b1;
          pol_nxt_s = sym_pol_s;
        end
      end
      SYM_ZERO: begin
        if (zrun_r == ZRUN_ERR) begin
          zero_err_s = 1'b1;
        end else begin
          zero_err_s = 1'b0;
        end
        if (zrun_r < ZRUN_MAX) begin
          zrun_nxt_s = zrun_r + 3'd1;
        end else begin
          zrun_nxt_s = zrun_r;
        end
      end
      SYM_ILL: begin
        ill_s      = 1'b1;
        zrun_nxt_s = 3'd0;
      end
      default: begin
        ill_s      = 1'b1;
        zrun_nxt_s = 3'd0;
      end
    endcase
  end

  // Window shift, run/lock tracking and error counting for one accepted symbol
  always_comb begin
    err_s    = ill_s | vv_err_s | zero_err_s;
    // A V clears the bit moving into d[3]: the B of B00V (already 0 for 000V)
    d_nxt_s  = {(viol_s ? 1'b0 : d_r[2]), d_r[1], d_r[0], mark_s};
    vd_nxt_s = {vd_r[2:0], 1'b1};
    if (err_s) begin
      run_nxt_s     = 5'd0;
      lock_nxt_s    = 1'b0;
      err_cnt_nxt_s = sat_inc8(err_cnt_r);
    end else begin
      if (run_r == RUN_LOCK) begin
        run_nxt_s = run_r;
      end else begin
        run_nxt_s = run_r + 5'd1;
      end
      if (run_nxt_s == RUN_LOCK) begin
        lock_nxt_s = 1'b1;
      end else begin
        lock_nxt_s = lock_r;
      end
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // Polarity FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      pol_r    <= POL_NONE;
      last_v_r <= POL_NONE;
    end else if (bus.en) begin
      pol_r    <= pol_nxt_s;
      last_v_r <= last_v_nxt_s;
    end else begin
      pol_r    <= pol_r;
      last_v_r <= last_v_r;
    end
  end

  // Datapath registers: windows, counters, lock and the output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r         <= 4'd0;
      vd_r        <= 4'd0;
      zrun_r      <= 3'd0;
      run_r       <= 5'd0;
      err_cnt_r   <= 8'd0;
      lock_r      <= 1'b0;
      nrz_out_r   <= 1'b0;
      nrz_valid_r <= 1'b0;
      v_flag_r    <= 1'b0;
      err_flag_r  <= 1'b0;
    end else if (bus.en) begin
      d_r         <= d_nxt_s;
      vd_r        <= vd_nxt_s;
      zrun_r      <= zrun_nxt_s;
      run_r       <= run_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
      lock_r      <= lock_nxt_s;
      nrz_out_r   <= d_r[3];
      nrz_valid_r <= vd_r[3];
      v_flag_r    <= viol_s;
      err_flag_r  <= err_s;
    end else begin
      nrz_out_r   <= 1'b0;
      nrz_valid_r <= 1'b0;
      v_flag_r    <= 1'b0;
      err_flag_r  <= 1'b0;
    end
  end

  assign bus.nrz_out   = nrz_out_r;
  assign bus.nrz_valid = nrz_valid_r;
  assign bus.v_flag    = v_flag_r;
  assign bus.err_flag  = err_flag_r;
  assign bus.lock      = lock_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_hdb3_decode_ctrl.sv
// Directed bench for hdb3_decode_ctrl: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written mid-stream reset and
// error-counter saturation sequences.
module tb_hdb3_decode_ctrl;

  localparam logic [1:0] SP = 2'b10;  // {p,n}: positive pulse
  localparam logic [1:0] SN = 2'b01;  // negative pulse
  localparam logic [1:0] SZ = 2'b00;  // zero
  localparam logic [1:0] SI = 2'b11;  // illegal

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] sym;
    logic [4:0] flags;  // {nrz_valid, nrz_out, v_flag, err_flag, lock}
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vec_t vecs[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [1:0] pre_syms [6];
  logic [1:0] post_syms [5];

  hdb3_decode_ctrl_if bus();

  hdb3_decode_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [1:0] s,
                     input logic [4:0] f, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.sym = s; v.flags = f; v.cnt = c;
    vecs.push_back(v);
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic drive(input logic r, input logic e, input logic [1:0] s);
    rst = r;
    bus.en = e;
    bus.p_in = s[1];
    bus.n_in = s[0];
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] outs();
    return {bus.nrz_valid, bus.nrz_valid & bus.nrz_out, bus.v_flag,
            bus.err_flag, bus.lock, bus.err_cnt};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b_%b_%b_%b_%b cnt=%0d, expected %b_%b_%b_%b_%b cnt=%0d (valid_nrz_v_err_lock)",
               name, act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  initial begin
    logic [4:0] f;
    logic [7:0] ecnt;
    rst = 1'b1; bus.en = 1'b0; bus.p_in = 1'b0; bus.n_in = 1'b0;

    // A: + - + - 0 0 -> NRZ 1 1 1 1 0 0, one idle (en=0, illegal rails) cycle
    add(1'b1, 1'b1, SI, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SZ, 5'b11000, 8'd0);
    add(1'b0, 1'b0, SI, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SZ, 5'b11000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b11000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b11000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b10000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b10000, 8'd0);
    // B: + 0 0 0 + (000V) then - + - + -> NRZ 1 0 0 0 0
    add(1'b1, 1'b1, SP, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SZ, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SZ, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SZ, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b11100, 8'd0);
    add(1'b0, 1'b1, SN, 5'b10000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b10000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b10000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b10000, 8'd0);
    // C: + - 0 0 - (B00V) then + - + - -> NRZ 1 0 0 0 0, B cleared
    add(1'b1, 1'b1, SP, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SZ, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SZ, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b11100, 8'd0);
    add(1'b0, 1'b1, SP, 5'b10000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b10000, 8'd0);
    add(1'b0, 1'b1, SP, 5'b10000, 8'd0);
    add(1'b0, 1'b1, SN, 5'b10000, 8'd0);
    // D: illegal, then five zeros -> errors on illegal and 4th zero
    add(1'b1, 1'b1, SP, 5'b00000, 8'd0);
    add(1'b0, 1'b1, SI, 5'b00010, 8'd1);
    add(1'b0, 1'b1, SZ, 5'b00000, 8'd1);
    add(1'b0, 1'b1, SZ, 5'b00000, 8'd1);
    add(1'b0, 1'b1, SZ, 5'b00000, 8'd1);
    add(1'b0, 1'b1, SZ, 5'b10010, 8'd2);
    add(1'b0, 1'b1, SZ, 5'b10000, 8'd2);
    // E: 16 alternating marks -> lock, then two equal-polarity Vs
    add(1'b1, 1'b1, SZ, 5'b00000, 8'd0);
    for (int i = 0; i < 16; i++) begin
      f = {(i >= 4), (i >= 4), 1'b0, 1'b0, (i == 15)};
      add(1'b0, 1'b1, ((i % 2) == 0) ? SP : SN, f, 8'd0);
    end
    add(1'b0, 1'b1, SN, 5'b11101, 8'd0);
    add(1'b0, 1'b1, SN, 5'b10110, 8'd1);
    add(1'b0, 1'b1, SP, 5'b10000, 8'd1);
    add(1'b0, 1'b1, SN, 5'b11000, 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].sym);
      check($sformatf("vec[%0d]", i), outs(),
            {vecs[i].flags[4], vecs[i].flags[4] & vecs[i].flags[3],
             vecs[i].flags[2:0], vecs[i].cnt});
    end

    // F: mid-stream reset with en toggling
    pre_syms  = '{SI, SP, SN, SP, SN, SP};
    post_syms = '{SP, SN, SP, SN, SP};
    drive(1'b1, 1'b1, SI);
    check("f_rst0", outs(), 13'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, pre_syms[i]);
      check($sformatf("f_pre[%0d]", i), outs(),
            {(i >= 4), (i == 5), 1'b0, (i == 0), 1'b0, 8'd1});
      drive(1'b0, 1'b0, SI);
      check($sformatf("f_pre_idle[%0d]", i), outs(), {5'b00000, 8'd1});
    end
    drive(1'b1, 1'b1, SP);
    check("f_rst_mid", outs(), 13'd0);
    drive(1'b1, 1'b0, SN);
    check("f_rst_mid2", outs(), 13'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, post_syms[i]);
      check($sformatf("f_post[%0d]", i), outs(),
            {(i == 4), (i == 4), 3'b000, 8'd0});
      drive(1'b0, 1'b0, SZ);
      check($sformatf("f_post_idle[%0d]", i), outs(), 13'd0);
    end

    // 300 forced errors: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, SI);
      ecnt = (i >= 254) ? 8'd255 : 8'(i + 1);
      check($sformatf("sat[%0d]", i), {3'b000, bus.v_flag, bus.err_flag, bus.lock, bus.err_cnt},
            {3'b000, 1'b0, 1'b1, 1'b0, ecnt});
    end
    drive(1'b0, 1'b0, SI);
    check("sat_hold", outs(), {5'b00000, 8'd255});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hdb3_decode_ctrl.md
HDB3_DECODE_CTRL -- requirements
Module: hdb3_decode_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port en, input, 1 bit: line-bit strobe; p_in/n_in are sampled only on cycles with en=1.
REQ-004 The block SHALL have the port p_in, input, 1 bit: positive-rail pulse of the HDB3 line symbol.
REQ-005 The block SHALL have the port n_in, input, 1 bit: negative-rail pulse of the HDB3 line symbol.
REQ-006 The block SHALL have the port nrz_out, output, 1 bit: decoded NRZ bit.
REQ-007 The block SHALL have the port nrz_valid, output, 1 bit: one-cycle strobe, nrz_out valid.
REQ-008 The block SHALL have the port v_flag, output, 1 bit: one-cycle pulse, violation (V) detected on the sampled symbol.
REQ-009 The block SHALL have the port err_flag, output, 1 bit: one-cycle pulse, line code error on the sampled symbol.
REQ-010 The block SHALL have the port lock, output, 1 bit: level, decoder in sync.
REQ-011 The block SHALL have the port err_cnt, output, 8 bits: saturating count of code errors.

Function
REQ-012 Symbol classification SHALL be: p_in=1,n_in=0 -> POS; p_in=0,n_in=1 -> NEG; both 0 -> ZERO; both 1 -> ILLEGAL.
REQ-013 Polarity state pol SHALL be in {NONE, POS, NEG}; it is NONE after reset.
REQ-014 A POS/NEG symbol equal to pol SHALL be a V: pol unchanged, v_flag=1 in the next cycle.
REQ-015 A POS/NEG symbol differing from pol, or arriving while pol=NONE, SHALL be a mark: pol := symbol polarity.
REQ-016 A 4-entry data window d[0..3] plus a 4-entry valid window vd[0..3] SHALL shift on each en=1 cycle: new bit enters d[0], d[3] is presented.
REQ-017 The bit entering d[0] SHALL be 1 for a mark and 0 for ZERO, V or ILLEGAL.
REQ-018 On a V, the same shift SHALL clear the bit moving into d[3] (the B of a B00V; no effect for 000V).
REQ-019 nrz_out/nrz_valid SHALL carry the bit leaving d[3]; latency = 4 en-strobes + 1 clk from input sample to nrz_valid.
REQ-020 nrz_valid SHALL be 0 until 4 symbols have been shifted in after reset (vd fill).
REQ-021 With en=0, the windows, pol and all counters SHALL hold; nrz_valid, v_flag and err_flag SHALL be 0.
REQ-022 err_flag SHALL pulse for an ILLEGAL symbol.
REQ-023 err_flag SHALL pulse for a V whose polarity equals that of the previous V (the last-V polarity register resets to NONE).
REQ-024 err_flag SHALL pulse on the 4th consecutive ZERO (3-bit zero-run counter, cleared by any pulse, saturating at 4).
REQ-025 When several error conditions coincide, a single err_flag pulse SHALL be produced and err_cnt incremented by 1.
REQ-026 err_cnt SHALL saturate at 255 and never wrap.
REQ-027 A 5-bit run counter SHALL count error-free symbols; lock asserts when it reaches 16 and stays asserted.
REQ-028 Any error SHALL clear the run counter and deassert lock in the same cycle as err_flag.

Reset
REQ-029 rst=1 at a clock edge SHALL clear d, vd, pol, the last-V polarity register, the zero-run counter, the run counter and err_cnt, taking priority over en, including mid-stream.
REQ-030 During and after reset, nrz_out, nrz_valid, v_flag, err_flag and lock SHALL be 0 and err_cnt SHALL be 0.

Verification
REQ-031 A bench SHALL cover: symbols +,-,+,-,0,0 with en=1 -> after fill, NRZ 1,1,1,1,0,0 with no v_flag or err_flag.
REQ-032 A bench SHALL cover: +,0,0,0,+ (000V) -> v_flag on the 5th symbol, NRZ 1,0,0,0,0.
REQ-033 A bench SHALL cover: +,-,0,0,- (B00V) -> v_flag on the 5th symbol, NRZ 1,0,0,0,0, with the B cleared.
REQ-034 A bench SHALL cover: ILLEGAL symbol, then a 5-zero run -> err_flag twice, err_cnt=2, lock low.
REQ-035 A bench SHALL cover: 16 alternating marks -> lock=1; then a same-polarity V twice -> err_flag, lock=0.
REQ-036 A bench SHALL cover: rst asserted mid-stream with en toggling -> all outputs 0 the next cycle, no nrz_valid until 4 new symbols, and err_cnt held at 255 under 300 forced errors.
